// File: rtl/logic_unit_arbiter_if.sv
// Request, logic-unit and response signals for logic_unit_arbiter.
// slave  : arbiter side (takes requests, drives the logic unit, returns results)
// master : requester/environment side
//   req0_* / req1_*   : requester operation channels (valid/ready, op, a, b)
//   lu_in1/lu_in2/lu_op, lu_out : shared combinational bitwise logic unit
//   rsp0_* / rsp1_*   : per-requester response handshakes
//   rsp_data          : result shared by both response channels
//   ops_done          : completed response handshake count
interface logic_unit_arbiter_if #(
   parameter int unsigned DATA_W = 32
);
   logic              req0_valid;
   logic              req0_ready;
   logic [1:0]        req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;

   logic              req1_valid;
   logic              req1_ready;
   logic [1:0]        req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;

   logic [DATA_W-1:0] lu_in1;
   logic [DATA_W-1:0] lu_in2;
   logic [1:0]        lu_op;
   logic [DATA_W-1:0] lu_out;

   logic              rsp0_valid;
   logic              rsp0_ready;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp_data;

   logic [15:0]       ops_done;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  lu_out,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready,
      output lu_in1, lu_in2, lu_op,
      output rsp0_valid, rsp1_valid, rsp_data,
      output ops_done
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output lu_out,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready,
      input  lu_in1, lu_in2, lu_op,
      input  rsp0_valid, rsp1_valid, rsp_data,
      input  ops_done
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a shared combinational bitwise logic unit.
// One operation in flight at a time: IDLE (arbitrate/accept) -> EXEC (drive
// the logic unit from latched operands) -> RESP (hold result until the
// winning requester takes it). Contention alternates between requesters,
// requester 0 first after reset.
// Ports:
//   clock  : sole clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : logic_unit_arbiter_if.slave (requests, logic unit, responses, ops_done)
module logic_unit_arbiter #(
   parameter int unsigned DATA_W = 32
) (
   input logic                  clock,
   input logic                  resetn,
   logic_unit_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q;
   logic              pri_q;       // requester favoured when both are valid
   logic              owner_q;     // requester owning the in-flight operation
   logic [1:0]        op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] res_q;
   logic              rsp0_valid_q;
   logic              rsp1_valid_q;
   logic [15:0]       ops_q;

   logic any_valid;
   logic grant1;
   logic accept;
   logic rsp_hs;

   always_comb begin
      any_valid = bus.req0_valid | bus.req1_valid;
      grant1    = bus.req1_valid & (~bus.req0_valid | pri_q);
      // resetn gating keeps both readies low while reset is held
      accept    = resetn & (state_q == IDLE) & any_valid;
      rsp_hs    = (state_q == RESP) & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
   end

   assign bus.req0_ready = accept & ~grant1;
   assign bus.req1_ready = accept & grant1;

   assign bus.lu_in1 = (state_q == EXEC) ? a_q  : '0;
   assign bus.lu_in2 = (state_q == EXEC) ? b_q  : '0;
   assign bus.lu_op  = (state_q == EXEC) ? op_q : 2'b00;

   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp_data   = (rsp0_valid_q | rsp1_valid_q) ? res_q : '0;
   assign bus.ops_done   = ops_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         pri_q        <= 1'b0;
         owner_q      <= 1'b0;
         op_q         <= 2'b00;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         ops_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  op_q    <= grant1 ? bus.req1_op : bus.req0_op;
                  a_q     <= grant1 ? bus.req1_a  : bus.req0_a;
                  b_q     <= grant1 ? bus.req1_b  : bus.req0_b;
                  owner_q <= grant1;
                  pri_q   <= ~grant1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q        <= bus.lu_out;
               rsp0_valid_q <= ~owner_q;
               rsp1_valid_q <= owner_q;
               state_q      <= RESP;
            end
            RESP: begin
               if (rsp_hs) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  ops_q        <= ops_q + 16'd1;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
